// File: rtl/vga_seq_pkg.sv
// Shared types and the demo scene table for the VGA demo sequencer.
package vga_seq_pkg;

    localparam int unsigned NUM_SCENES = 8;
    localparam int unsigned SCENE_W    = 3;
    localparam int unsigned MODE_W     = 4;
    localparam int unsigned DEPTH_W    = 3;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_SWITCH = 2'd1,
        ST_MANUAL = 2'd2
    } seq_state_e;

    typedef struct packed {
        logic [MODE_W-1:0]  mode;
        logic [DEPTH_W-1:0] depth;
    } scene_t;

    localparam scene_t SCENE_TABLE [NUM_SCENES] = '{
        '{mode: 4'd1, depth: 3'd7},
        '{mode: 4'd4, depth: 3'd6},
        '{mode: 4'd3, depth: 3'd5},
        '{mode: 4'd5, depth: 3'd4},
        '{mode: 4'd2, depth: 3'd3},
        '{mode: 4'd4, depth: 3'd2},
        '{mode: 4'd7, depth: 3'd1},
        '{mode: 4'd6, depth: 3'd0}
    };

    function automatic scene_t scene_lookup(input logic [SCENE_W-1:0] idx);
        return SCENE_TABLE[idx];
    endfunction

endpackage

// File: rtl/vga_seq_vsync_edge.sv
// Samples vsync once and emits a one-cycle frame tick on its asserting edge.
module vga_seq_vsync_edge #(
    parameter int unsigned ACTIVE_LOW = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic vsync_i,
    output logic frame_tick_o
);

    localparam logic INACTIVE = (ACTIVE_LOW != 0);

    logic r_vsync;
    logic r_tick;
    logic w_edge;

    // Asserting edge: input now at the active level, previous sample inactive.
    assign w_edge = (vsync_i != INACTIVE) && (r_vsync == INACTIVE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vsync <= INACTIVE;
            r_tick  <= 1'b0;
        end else begin
            r_vsync <= vsync_i;
            r_tick  <= w_edge;
        end
    end

    assign frame_tick_o = r_tick;

endmodule

// File: rtl/vga_demo_sequencer.sv
// Cycles the pattern generator through demo scenes, with manual override and
// a reset pulse on every scene change. Define VGA_SEQ_FADE_EN to fade depth in.
module vga_demo_sequencer
    import vga_seq_pkg::*;
#(
    parameter int unsigned DWELL_FRAMES     = 128,
    parameter int unsigned RST_CYCLES       = 4,
    parameter int unsigned VSYNC_ACTIVE_LOW = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               vsync_i,
    input  logic               manual_i,
    input  logic [MODE_W-1:0]  manual_mode_i,
    input  logic [DEPTH_W-1:0] manual_depth_i,
    input  logic               pause_i,
    output logic [MODE_W-1:0]  mode_o,
    output logic [DEPTH_W-1:0] depth_o,
    output logic [SCENE_W-1:0] scene_o,
    output logic               project_rst_n_o,
    output logic               frame_tick_o
);

    localparam int unsigned      CNT_W      = 8;
    localparam int unsigned      RCNT_W     = 4;
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_FRAMES - 1);
    localparam logic [RCNT_W-1:0] RST_LOAD   = RCNT_W'(RST_CYCLES);
    localparam logic [RCNT_W-1:0] RST_RELOAD = RCNT_W'(RST_CYCLES - 1);

    seq_state_e          r_state, w_state_nxt;
    logic [SCENE_W-1:0]  r_scene, w_scene_nxt;
    logic [CNT_W-1:0]    r_frame_cnt, w_frame_cnt_nxt;
    logic [RCNT_W-1:0]   r_rst_cnt, w_rst_cnt_nxt;
    logic [MODE_W-1:0]   r_mode, w_mode_nxt;
    logic [DEPTH_W-1:0]  r_depth, w_depth_nxt;
    logic                r_prst_n, w_prst_n_nxt;

    logic                w_tick;
    logic                w_advance;
    scene_t              w_cur;
    scene_t              w_new;
    logic [DEPTH_W-1:0]  w_run_depth;
    logic [DEPTH_W-1:0]  w_cur_entry_depth;
    logic [DEPTH_W-1:0]  w_new_entry_depth;

    vga_seq_vsync_edge #(
        .ACTIVE_LOW (VSYNC_ACTIVE_LOW)
    ) u_vsync_edge (
        .clk          (clk),
        .rst_n        (rst_n),
        .vsync_i      (vsync_i),
        .frame_tick_o (w_tick)
    );

    assign w_advance = w_tick && !pause_i;
    assign w_cur     = scene_lookup(r_scene);
    assign w_new     = scene_lookup(r_scene + SCENE_W'(1));

`ifdef VGA_SEQ_FADE_EN
    // Depth ramps from 0 up to the table value, one step per frame.
    assign w_run_depth       = (w_tick && (r_depth < w_cur.depth)) ? r_depth + DEPTH_W'(1) : r_depth;
    assign w_cur_entry_depth = '0;
    assign w_new_entry_depth = '0;
`else
    assign w_run_depth       = r_depth;
    assign w_cur_entry_depth = w_cur.depth;
    assign w_new_entry_depth = w_new.depth;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_SWITCH;
            r_scene     <= '0;
            r_frame_cnt <= '0;
            r_rst_cnt   <= RST_LOAD;
            r_mode      <= SCENE_TABLE[0].mode;
            r_depth     <= SCENE_TABLE[0].depth;
            r_prst_n    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_scene     <= w_scene_nxt;
            r_frame_cnt <= w_frame_cnt_nxt;
            r_rst_cnt   <= w_rst_cnt_nxt;
            r_mode      <= w_mode_nxt;
            r_depth     <= w_depth_nxt;
            r_prst_n    <= w_prst_n_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_scene_nxt     = r_scene;
        w_frame_cnt_nxt = r_frame_cnt;
        w_rst_cnt_nxt   = r_rst_cnt;
        w_mode_nxt      = r_mode;
        w_depth_nxt     = r_depth;
        w_prst_n_nxt    = r_prst_n;

        case (r_state)
            ST_RUN: begin
                if (manual_i) begin
                    w_state_nxt = ST_MANUAL;
                    w_mode_nxt  = manual_mode_i;
                    w_depth_nxt = manual_depth_i;
                end else begin
                    w_depth_nxt = w_run_depth;
                    if (w_advance) begin
                        // >= also recovers a count that overran during SWITCH
                        if (r_frame_cnt >= DWELL_LAST) begin
                            w_frame_cnt_nxt = '0;
                            w_scene_nxt     = r_scene + SCENE_W'(1);
                            w_state_nxt     = ST_SWITCH;
                            w_mode_nxt      = w_new.mode;
                            w_depth_nxt     = w_new_entry_depth;
                            w_prst_n_nxt    = 1'b0;
                            w_rst_cnt_nxt   = RST_RELOAD;
                        end else begin
                            w_frame_cnt_nxt = r_frame_cnt + CNT_W'(1);
                        end
                    end
                end
            end
            ST_SWITCH: begin
                w_depth_nxt = w_run_depth;
                if (w_advance) begin
                    w_frame_cnt_nxt = r_frame_cnt + CNT_W'(1);
                end
                if (r_rst_cnt != '0) begin
                    w_rst_cnt_nxt = r_rst_cnt - RCNT_W'(1);
                end else begin
                    w_prst_n_nxt = 1'b1;
                    if (manual_i) begin
                        w_state_nxt = ST_MANUAL;
                        w_mode_nxt  = manual_mode_i;
                        w_depth_nxt = manual_depth_i;
                    end else begin
                        w_state_nxt = ST_RUN;
                    end
                end
            end
            ST_MANUAL: begin
                if (manual_i) begin
                    w_mode_nxt  = manual_mode_i;
                    w_depth_nxt = manual_depth_i;
                end else begin
                    w_frame_cnt_nxt = '0;
                    w_state_nxt     = ST_SWITCH;
                    w_mode_nxt      = w_cur.mode;
                    w_depth_nxt     = w_cur_entry_depth;
                    w_prst_n_nxt    = 1'b0;
                    w_rst_cnt_nxt   = RST_RELOAD;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    assign mode_o          = r_mode;
    assign depth_o         = r_depth;
    assign scene_o         = r_scene;
    assign project_rst_n_o = r_prst_n;
    assign frame_tick_o    = w_tick;

endmodule

// File: tb/tb_vga_demo_sequencer.sv
// Self-checking bench for vga_demo_sequencer: directed scenarios plus random
// stimulus checked every cycle against a frame/scene-level reference model.
module tb_vga_demo_sequencer;

    localparam int DWELL = 3;
    localparam int RSTC  = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       vsync_i;
    logic       manual_i;
    logic [3:0] manual_mode_i;
    logic [2:0] manual_depth_i;
    logic       pause_i;
    logic [3:0] mode_o;
    logic [2:0] depth_o;
    logic [2:0] scene_o;
    logic       project_rst_n_o;
    logic       frame_tick_o;

    int checks = 0;
    int errors = 0;
    int tick_total = 0;

    vga_demo_sequencer #(
        .DWELL_FRAMES     (DWELL),
        .RST_CYCLES       (RSTC),
        .VSYNC_ACTIVE_LOW (1)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .vsync_i         (vsync_i),
        .manual_i        (manual_i),
        .manual_mode_i   (manual_mode_i),
        .manual_depth_i  (manual_depth_i),
        .pause_i         (pause_i),
        .mode_o          (mode_o),
        .depth_o         (depth_o),
        .scene_o         (scene_o),
        .project_rst_n_o (project_rst_n_o),
        .frame_tick_o    (frame_tick_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t actual=%0d required=%0d", nm, $time, act, exp);
        end
    endtask

    // Reference model: phase 0 = playing, 1 = reset pulse, 2 = manual
    int tbl_mode  [8] = '{1, 4, 3, 5, 2, 4, 7, 6};
    int tbl_depth [8] = '{7, 6, 5, 4, 3, 2, 1, 0};
    int m_scene, m_cnt, m_phase, m_left, m_mode, m_depth;
    bit m_tick, m_prev_act, m_valid = 0;

    task automatic m_start_pulse();
        m_phase = 1;
        m_left  = RSTC;
        m_mode  = tbl_mode[m_scene];
`ifdef VGA_SEQ_FADE_EN
        m_depth = 0;
`else
        m_depth = tbl_depth[m_scene];
`endif
    endtask

    task automatic m_fade();
`ifdef VGA_SEQ_FADE_EN
        if (m_tick && m_depth < tbl_depth[m_scene]) m_depth = m_depth + 1;
`endif
    endtask

    task automatic m_load_manual();
        m_phase = 2;
        m_mode  = int'(manual_mode_i);
        m_depth = int'(manual_depth_i);
    endtask

    always @(posedge clk) begin
        bit act, adv;
        act = (vsync_i == 1'b0);
        if (!rst_n) begin
            m_scene = 0; m_cnt = 0; m_phase = 1; m_left = RSTC + 1;
            m_mode = tbl_mode[0]; m_depth = tbl_depth[0];
            m_tick = 0; m_prev_act = 0; m_valid = 1;
        end else begin
            adv = m_tick && !pause_i;
            case (m_phase)
                0: begin
                    if (manual_i) m_load_manual();
                    else begin
                        m_fade();
                        if (adv) begin
                            if (m_cnt >= DWELL - 1) begin
                                m_cnt = 0;
                                m_scene = (m_scene + 1) % 8;
                                m_start_pulse();
                            end else m_cnt = m_cnt + 1;
                        end
                    end
                end
                1: begin
                    if (adv) m_cnt = m_cnt + 1;
                    m_fade();
                    m_left = m_left - 1;
                    if (m_left == 0) begin
                        if (manual_i) m_load_manual();
                        else m_phase = 0;
                    end
                end
                default: begin
                    if (manual_i) m_load_manual();
                    else begin
                        m_cnt = 0;
                        m_start_pulse();
                    end
                end
            endcase
            m_tick = act && !m_prev_act;
            m_prev_act = act;
        end
    end

    always @(negedge clk) begin
        if (frame_tick_o === 1'b1) tick_total++;
        if (m_valid) begin
            chk("model_mode",  32'(mode_o),  32'(m_mode));
            chk("model_depth", 32'(depth_o), 32'(m_depth));
            chk("model_scene", 32'(scene_o), 32'(m_scene));
            chk("model_prst",  32'(project_rst_n_o), 32'(m_left == 0));
            chk("model_tick",  32'(frame_tick_o), 32'(m_tick));
        end
    end

    task automatic vs_pulse();
        @(negedge clk) vsync_i = 1'b0;
        repeat (2) @(negedge clk);
        vsync_i = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    // Counts low cycles of project_rst_n_o, stopping at the first high after a low.
    task automatic measure_pulse(output int lows);
        lows = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (project_rst_n_o == 1'b0) lows++;
            else if (lows > 0) break;
        end
    endtask

    initial begin
        int lows, t0;
        rst_n = 1'b0; vsync_i = 1'b1; manual_i = 1'b0;
        manual_mode_i = '0; manual_depth_i = '0; pause_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_prst",  32'(project_rst_n_o), 0);
        chk("rst_mode",  32'(mode_o), 1);
        chk("rst_depth", 32'(depth_o), 7);
        chk("rst_scene", 32'(scene_o), 0);
        chk("rst_tick",  32'(frame_tick_o), 0);

        rst_n = 1'b1;
        measure_pulse(lows);
        chk("release_low_cycles", 32'(lows), 4);
        chk("release_mode",  32'(mode_o), 1);
        chk("release_depth", 32'(depth_o), 7);
        chk("release_scene", 32'(scene_o), 0);

        // Third frame of scene 0 advances to scene 1
        repeat (2) vs_pulse();
        @(negedge clk) vsync_i = 1'b0;
        measure_pulse(lows);
        vsync_i = 1'b1;
        chk("switch_low_cycles", 32'(lows), 4);
        chk("switch_scene", 32'(scene_o), 1);
        chk("switch_mode",  32'(mode_o), 4);
`ifndef VGA_SEQ_FADE_EN
        chk("switch_depth", 32'(depth_o), 6);
`endif
        repeat (4) @(negedge clk);

        repeat (21) vs_pulse();
        chk("wrap_scene", 32'(scene_o), 0);
        chk("wrap_mode",  32'(mode_o), 1);

        pause_i = 1'b1;
        t0 = tick_total;
        repeat (10) vs_pulse();
        chk("pause_ticks", 32'(tick_total - t0), 10);
        chk("pause_scene", 32'(scene_o), 0);
        pause_i = 1'b0;

        @(negedge clk) begin manual_i = 1'b1; manual_mode_i = 4'd9; manual_depth_i = 3'd2; end
        @(negedge clk);
        chk("manual_mode",  32'(mode_o), 9);
        chk("manual_depth", 32'(depth_o), 2);
        chk("manual_prst",  32'(project_rst_n_o), 1);
        repeat (4) vs_pulse();
        chk("manual_scene_hold", 32'(scene_o), 0);
        @(negedge clk) manual_i = 1'b0;
        measure_pulse(lows);
        chk("manual_exit_low_cycles", 32'(lows), 4);
        chk("manual_exit_mode", 32'(mode_o), 1);
`ifndef VGA_SEQ_FADE_EN
        chk("manual_exit_depth", 32'(depth_o), 7);
`endif

        // Reset in the middle of a scene-change pulse
        repeat (2) vs_pulse();
        @(negedge clk) vsync_i = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_prst",  32'(project_rst_n_o), 0);
        chk("midrst_scene", 32'(scene_o), 0);
        chk("midrst_mode",  32'(mode_o), 1);
        vsync_i = 1'b1;
        rst_n = 1'b1;
        measure_pulse(lows);
        chk("midrst_low_cycles", 32'(lows), 4);

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 5) == 0) vsync_i = ~vsync_i;
            if ($urandom_range(0, 40) == 0) pause_i = ~pause_i;
            if ($urandom_range(0, 80) == 0) manual_i = ~manual_i;
            manual_mode_i  = 4'($urandom);
            manual_depth_i = 3'($urandom);
            rst_n = ($urandom_range(0, 499) != 0);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog t=%0t actual=timeout required=finish", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/vga_demo_sequencer.md
VGA_DEMO_SEQUENCER -- requirements
Module: vga_demo_sequencer

Interface
REQ-001 SHALL have parameter DWELL_FRAMES, default 128: frames per scene; legal range 2..255.
REQ-002 SHALL have parameter RST_CYCLES, default 4: project reset pulse length in clk cycles; legal range 1..15.
REQ-003 SHALL have parameter VSYNC_ACTIVE_LOW, default 1: 1 = vsync_i active-low, 0 = active-high.
REQ-004 SHALL have port clk, input, 1: clock.
REQ-005 SHALL have port rst_n, input, 1: reset; synchronous, active-low.
REQ-006 SHALL have port vsync_i, input, 1: vsync from the pattern generator, clk-synchronous.
REQ-007 SHALL have port manual_i, input, 1: manual override enable.
REQ-008 SHALL have port manual_mode_i, input, 4: override mode nibble.
REQ-009 SHALL have port manual_depth_i, input, 3: override colour depth.
REQ-010 SHALL have port pause_i, input, 1: freeze dwell counting.
REQ-011 SHALL have port mode_o, output, 4: mode nibble to the pattern generator.
REQ-012 SHALL have port depth_o, output, 3: colour depth to the dither stage.
REQ-013 SHALL have port scene_o, output, 3: current scene index.
REQ-014 SHALL have port project_rst_n_o, output, 1: active-low reset to the pattern generator.
REQ-015 SHALL have port frame_tick_o, output, 1: one-cycle pulse per frame.

Function
REQ-016 SHALL register vsync_i once and pulse frame_tick_o for exactly one cycle, in the cycle after the registered active edge (assert edge, polarity per VSYNC_ACTIVE_LOW).
REQ-017 SHALL implement states RUN, SWITCH, MANUAL.
REQ-018 In RUN, on frame_tick_o with pause_i low: if frame_cnt == DWELL_FRAMES-1, then frame_cnt <= 0, scene <= scene+1 (7 wraps to 0), next state SWITCH; otherwise frame_cnt <= frame_cnt+1.
REQ-019 pause_i high SHALL hold frame_cnt and scene; frame_tick_o still pulses.
REQ-020 On SWITCH entry, mode_o/depth_o SHALL take the new scene's table values, and project_rst_n_o SHALL be low for exactly RST_CYCLES cycles starting that same cycle; the state then returns to RUN.
REQ-021 Frame ticks during SWITCH SHALL increment frame_cnt; dwell expiry is evaluated only in RUN.
REQ-022 manual_i high SHALL enter MANUAL (from SWITCH only after the pulse completes); mode_o/depth_o follow manual inputs with 1-cycle latency; scene and frame_cnt hold; no reset pulse is issued.
REQ-023 manual_i falling SHALL clear frame_cnt and enter SWITCH with the unchanged scene, restoring its table values with a reset pulse.
REQ-024 scene_o SHALL always equal the scene register, including in MANUAL.

Reset
REQ-025 While rst_n is low: scene 0, frame_cnt 0, frame_tick_o 0, project_rst_n_o 0, mode_o/depth_o = scene-0 table entry, vsync register = inactive level.
REQ-026 After rst_n rises, the block SHALL be in SWITCH, holding project_rst_n_o low for RST_CYCLES more cycles.
REQ-027 Reset asserted mid-SWITCH or mid-MANUAL SHALL abort the current state and apply REQ-025 immediately.

Configuration
REQ-028 With VGA_SEQ_FADE_EN defined: on each SWITCH entry, depth_o SHALL start at 0 and increment by 1 per frame tick until it reaches the table depth; MANUAL bypasses the fade.
REQ-029 Without VGA_SEQ_FADE_EN: depth_o SHALL take the table depth immediately on SWITCH entry, and no fade logic is present.

Structure
REQ-030 Package vga_seq_pkg SHALL hold: the state enum, scene_t {mode[3:0], depth[2:0]}, NUM_SCENES=8, and SCENE_TABLE with modes 1,4,3,5,2,4,7,6 and depths 7,6,5,4,3,2,1,0.
REQ-031 Sub-module vga_seq_vsync_edge SHALL implement the vsync register, polarity handling and frame_tick_o.

Verification
REQ-032 Reset release with DWELL_FRAMES=3, RST_CYCLES=4 -> project_rst_n_o low for 4 cycles after release; mode_o=1, depth_o=7, scene_o=0.
REQ-033 Three vsync pulses -> on the 3rd tick scene_o=1, mode_o=4, depth_o=6, project_rst_n_o low for 4 cycles.
REQ-034 24 frames with no pause -> scene_o wraps 7->0 and mode_o returns to 1.
REQ-035 manual_i=1 with mode 9, depth 2 -> next cycle mode_o=9, depth_o=2, no reset pulse; release -> scene-table values restored with a 4-cycle pulse.
REQ-036 pause_i=1 across 10 ticks -> scene_o unchanged and 10 frame_tick_o pulses observed.
REQ-037 With VGA_SEQ_FADE_EN, switch to scene 1 -> depth_o sequence 0,1,2,3,4,5,6 on successive ticks.
